// File: rtl/locked_serial_word_converter.sv
// Serial word converter that retransmits a framed word only when it differs from the last one sent.
// Define LOCKED_CONVERTER_LOCK_EN to enable the keyed input-corruption layer.
module locked_serial_word_converter #(
    parameter int unsigned                     WORD_W   = 8,
    parameter int unsigned                     NUM_KEYS = 4,
    parameter int unsigned                     KEY_W    = 3,
    parameter logic [NUM_KEYS*KEY_W-1:0]       KEY_VEC  = {3'd5, 3'd2, 3'd7, 3'd4}
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               X,
    input  logic [KEY_W-1:0]                   keyinput,
    output logic                               Y_REG,
    output logic                               busy,
    output logic [$clog2(NUM_KEYS)-1:0]        phase
);

    localparam int unsigned PH_W  = $clog2(NUM_KEYS);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CMP,
        SEND
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] old_q;
    logic [WORD_W-1:0] out_q;
    logic              y_q;
    logic              busy_q;
    logic [PH_W-1:0]   phase_q;
    logic [PH_W-1:0]   phase_d;
    logic              xe;

    always_comb begin
        phase_d = (phase_q == PH_W'(NUM_KEYS - 1)) ? '0 : phase_q + 1'b1;
    end

`ifdef LOCKED_CONVERTER_LOCK_EN
    logic [KEY_W-1:0] key_exp;

    // A wrong key for the current phase inverts the sampled bit, start bit included.
    always_comb begin
        key_exp = KEY_VEC[phase_q*KEY_W +: KEY_W];
        xe      = X ^ (keyinput != key_exp);
    end
`else
    logic unused_key;

    assign unused_key = ^{keyinput, KEY_VEC};

    always_comb begin
        xe = X;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            old_q     <= '0;
            out_q     <= '0;
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    y_q <= 1'b0;
                    if (xe) begin
                        state_q   <= RECV;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                RECV: begin
                    shift_q   <= {shift_q[WORD_W-2:0], xe};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    // The start bit is launched here so it is on the line during the first SEND cycle.
                    if (shift_q != old_q) begin
                        old_q     <= shift_q;
                        out_q     <= shift_q;
                        bit_cnt_q <= '0;
                        y_q       <= 1'b1;
                        state_q   <= SEND;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_cnt_q == CNT_W'(WORD_W)) begin
                        y_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        y_q       <= out_q[WORD_W-1];
                        out_q     <= {out_q[WORD_W-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    y_q     <= 1'b0;
                end
            endcase
        end
    end

    assign Y_REG = y_q;
    assign busy  = busy_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_locked_serial_word_converter.sv
// Randomised scoreboard bench for locked_serial_word_converter; expectations come from a frame-level model.
module tb_locked_serial_word_converter;

    localparam int W  = 8;
    localparam int NK = 4;
    localparam int KW = 3;
`ifdef LOCKED_CONVERTER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    // Expected key per phase: phase p owns bits [p*KW +: KW] of {5,2,7,4}.
    int keys [NK] = '{4, 7, 2, 5};

    logic          clock = 1'b0;
    logic          reset_n;
    logic          X;
    logic [KW-1:0] keyinput;
    logic          Y_REG;
    logic          busy;
    logic [1:0]    phase;

    locked_serial_word_converter #(
        .WORD_W   (W),
        .NUM_KEYS (NK),
        .KEY_W    (KW),
        .KEY_VEC  ({3'd5, 3'd2, 3'd7, 3'd4})
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .X        (X),
        .keyinput (keyinput),
        .Y_REG    (Y_REG),
        .busy     (busy),
        .phase    (phase)
    );

    always #5 clock = ~clock;

    // Index of the next rising edge, as seen from a falling edge.
    int cyc;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        logic [W-1:0] word;
        int           at;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] last_sent;
    int           tests = 0;
    int           fails = 0;
    int           p5;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // mode 0: correct key (random key when unlocked), 1: constant 5, 2: random key
    task automatic drive(input logic x, input int mode, output int at, output logic mism);
        int          p;
        logic [KW-1:0] k;
        @(negedge clock);
        p = cyc % NK;
        case (mode)
            1:       k = 3'd5;
            2:       k = KW'($urandom_range(0, 7));
            default: k = LOCK ? KW'(keys[p]) : KW'($urandom_range(0, 7));
        endcase
        mism     = LOCK && (int'(k) != keys[p]);
        at       = cyc;
        X        = x;
        keyinput = k;
        check("phase", int'(phase), p);
    endtask

    task automatic idle(input int n);
        int   at;
        logic m;
        repeat (n) drive(1'b0, 0, at, m);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input int mode, input int gap);
        int           s;
        int           at;
        logic         m;
        logic [W-1:0] w;
        exp_t         e;
        if (mode == 1) begin
            while (((cyc + 1) % NK) != p5) drive(1'b0, 0, at, m);
        end
        drive(1'b1, (mode == 1) ? 1 : 0, s, m);
        for (int i = W - 1; i >= 0; i--) begin
            drive(data[i], mode, at, m);
            w[i] = data[i] ^ m;
        end
        if (w != last_sent) begin
            e.word = w;
            e.at   = s + W + 1;
            q.push_back(e);
            last_sent = w;
        end
        idle(gap);
    endtask

    // Monitor: a 1 on Y_REG while idle is a start bit; collect the word and score it.
    initial begin
        int           mcnt;
        int           mstart;
        logic [W-1:0] mword;
        exp_t         e;
        mcnt = 0;
        mword = '0;
        mstart = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mcnt = 0;
            end else if (mcnt == 0) begin
                if (Y_REG) begin
                    mstart = cyc - 1;
                    mword  = '0;
                    mcnt   = 1;
                end
            end else if (mcnt <= W) begin
                mword = {mword[W-2:0], Y_REG};
                mcnt++;
                if (mcnt == W + 1) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got word 0x%0h, expected no output", mword);
                    end else begin
                        e = q.pop_front();
                        check("word", int'(mword), int'(e.word));
                        check("start_edge", mstart, e.at);
                    end
                end
            end else begin
                check("line_idle_after_word", int'(Y_REG), 0);
                mcnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int   at;
        int   n;
        logic m;
        logic [W-1:0] d;
        for (int p = 0; p < NK; p++) if (keys[p] == 5) p5 = p;
        last_sent = '0;
        X         = 1'b0;
        keyinput  = '0;
        reset_n   = 1'b0;
        #1;
        check("reset_Y_REG", int'(Y_REG), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_phase", int'(phase), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        send_frame(8'h00, 0, W + 4);
        send_frame(8'h01, 0, W + 4);
        send_frame(8'h00, 0, W + 4);
        send_frame(8'hA5, 0, W + 4);

        // Duplicate word, plus a start bit offered during CMP that must be lost.
        send_frame(8'hA5, 0, 0);
        drive(1'b1, 0, at, m);
        check("dup_busy_in_cmp", int'(busy), 1);
        drive(1'b0, 0, at, m);
        check("dup_busy_after_cmp", int'(busy), 0);
        check("dup_Y_REG", int'(Y_REG), 0);
        idle(W + 4);

        send_frame(8'hA5, 1, W + 4);
        send_frame(8'h5A, 0, W + 4);

        // Reset in the middle of RECV, after four payload bits.
        drive(1'b1, 0, at, m);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, at, m);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_Y_REG", int'(Y_REG), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_phase", int'(phase), 0);
        X = 1'b0;
        @(negedge clock);
        reset_n   = 1'b1;
        last_sent = '0;
        q.delete();
        send_frame(8'h3C, 0, W + 4);

        // Minimum inter-frame gap: next start bit right after SEND finishes.
        send_frame(8'hC3, 0, W + 2);
        send_frame(8'h96, 0, W + 2);
        send_frame(8'h69, 0, W + 4);

        for (int t = 0; t < 30; t++) begin
            d = ($urandom_range(0, 3) == 0) ? last_sent : W'($urandom);
            send_frame(d, ($urandom_range(0, 1) == 0) ? 0 : 2, $urandom_range(W + 2, W + 6));
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        idle(W + 4);
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
